cpu_fetch: RTL



---
 rtl/cpu_fetch_if.sv | 38 +++
 rtl/cpu_fetch.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_if.sv
// Fetch-stage bundle: Wishbone classic read master, instruction FIFO write port,
// and the redirect/PC handshake with the FIFO.
`timescale 1ns/1ps
interface cpu_fetch_if;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        ififo_full_i;
  logic        ififo_wen_o;
  logic [31:0] ififo_data_o;
  logic        branch_p_i;
  logic [31:0] branch_target_i;
  logic        newPC_p_o;
  logic [31:0] PC_o;
  logic        fetch_fault_o;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    input  ififo_full_i,
    output ififo_wen_o, ififo_data_o,
    input  branch_p_i, branch_target_i,
    output newPC_p_o, PC_o, fetch_fault_o
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i,
    output ififo_full_i,
    input  ififo_wen_o, ififo_data_o,
    output branch_p_i, branch_target_i,
    input  newPC_p_o, PC_o, fetch_fault_o
  );
endinterface

// File: rtl/cpu_fetch.sv
// Instruction fetch: single Wishbone reads into the instruction FIFO with halfword realignment.
// Optional bus-error handling is enabled by defining CPU_FETCH_ERR_EN.
`timescale 1ns/1ps
module cpu_fetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000
) (
  input logic         clk_i,
  input logic         rst_i,
  cpu_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_SEED  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_REQ   = 2'd2,
    ST_PRIME = 2'd3
  } state_t;

  localparam logic [31:0] BOOT_WORD = {BOOT_ADDRESS[31:2], 2'b00};

  state_t      state_r, state_nxt_s;
  logic        cyc_r, cyc_nxt_s;
  logic [31:0] adr_r, adr_nxt_s;
  logic [31:0] fetch_adr_r, fetch_adr_nxt_s;
  logic        realign_r, realign_nxt_s;
  logic [15:0] held_lo_r, held_lo_nxt_s;
  logic        held_vld_r, held_vld_nxt_s;
  logic        wen_r, wen_nxt_s;
  logic [31:0] data_r, data_nxt_s;
  logic        newpc_r, newpc_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic        fault_r, fault_nxt_s;
  logic        err_s;

`ifdef CPU_FETCH_ERR_EN
  assign err_s = bus.wb_err_i;
`else
  // Bus errors are not observed; the fault flag can never set.
  assign err_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_SEED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output logic; a redirect overrides everything else.
  always_comb begin
    state_nxt_s     = state_r;
    cyc_nxt_s       = cyc_r;
    adr_nxt_s       = adr_r;
    fetch_adr_nxt_s = fetch_adr_r;
    realign_nxt_s   = realign_r;
    held_lo_nxt_s   = held_lo_r;
    held_vld_nxt_s  = held_vld_r;
    wen_nxt_s       = 1'b0;
    data_nxt_s      = data_r;
    newpc_nxt_s     = 1'b0;
    pc_nxt_s        = pc_r;
    fault_nxt_s     = fault_r;

    if (bus.branch_p_i) begin
      state_nxt_s     = ST_IDLE;
      cyc_nxt_s       = 1'b0;
      newpc_nxt_s     = 1'b1;
      pc_nxt_s        = bus.branch_target_i;
      fetch_adr_nxt_s = {bus.branch_target_i[31:2], 2'b00};
      realign_nxt_s   = bus.branch_target_i[1];
      held_vld_nxt_s  = 1'b0;
      fault_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        ST_SEED: begin
          state_nxt_s     = ST_IDLE;
          newpc_nxt_s     = 1'b1;
          pc_nxt_s        = BOOT_ADDRESS;
          fetch_adr_nxt_s = BOOT_WORD;
          realign_nxt_s   = BOOT_ADDRESS[1];
          held_vld_nxt_s  = 1'b0;
        end
        ST_IDLE: begin
          // Waiting one cycle after a write keeps a full FIFO from being overrun.
          if (!bus.ififo_full_i && !wen_r && !fault_r) begin
            state_nxt_s = ST_REQ;
            cyc_nxt_s   = 1'b1;
            adr_nxt_s   = fetch_adr_r;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (err_s) begin
            state_nxt_s = ST_IDLE;
            cyc_nxt_s   = 1'b0;
            fault_nxt_s = 1'b1;
          end else if (bus.wb_ack_i) begin
            cyc_nxt_s       = 1'b0;
            fetch_adr_nxt_s = fetch_adr_r + 32'd4;
            if (!realign_r) begin
              state_nxt_s = ST_IDLE;
              data_nxt_s  = bus.wb_dat_i;
              wen_nxt_s   = 1'b1;
            end else if (!held_vld_r) begin
              state_nxt_s   = ST_PRIME;
              held_lo_nxt_s = bus.wb_dat_i[15:0];
            end else begin
              state_nxt_s   = ST_IDLE;
              data_nxt_s    = {held_lo_r, bus.wb_dat_i[31:16]};
              held_lo_nxt_s = bus.wb_dat_i[15:0];
              wen_nxt_s     = 1'b1;
            end
          end else begin
            state_nxt_s = ST_REQ;
          end
        end
        ST_PRIME: begin
          state_nxt_s    = ST_IDLE;
          held_vld_nxt_s = 1'b1;
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cyc_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_r       <= 1'b0;
      adr_r       <= 32'h0000_0000;
      fetch_adr_r <= BOOT_WORD;
      realign_r   <= 1'b0;
      held_lo_r   <= 16'h0000;
      held_vld_r  <= 1'b0;
      wen_r       <= 1'b0;
      data_r      <= 32'h0000_0000;
      newpc_r     <= 1'b0;
      pc_r        <= BOOT_ADDRESS;
      fault_r     <= 1'b0;
    end else begin
      cyc_r       <= cyc_nxt_s;
      adr_r       <= adr_nxt_s;
      fetch_adr_r <= fetch_adr_nxt_s;
      realign_r   <= realign_nxt_s;
      held_lo_r   <= held_lo_nxt_s;
      held_vld_r  <= held_vld_nxt_s;
      wen_r       <= wen_nxt_s;
      data_r      <= data_nxt_s;
      newpc_r     <= newpc_nxt_s;
      pc_r        <= pc_nxt_s;
      fault_r     <= fault_nxt_s;
    end
  end

  assign bus.wb_adr_o      = adr_r;
  assign bus.wb_cyc_o      = cyc_r;
  assign bus.wb_stb_o      = cyc_r;
  assign bus.wb_sel_o      = 4'hF;
  assign bus.ififo_wen_o   = wen_r;
  assign bus.ififo_data_o  = data_r;
  assign bus.newPC_p_o     = newpc_r;
  assign bus.PC_o          = pc_r;
  assign bus.fetch_fault_o = fault_r;

endmodule
